// File: rtl/led_pkg.sv
// Shared types for the status-LED driver: channel modes and the default channel
// configuration payload.
package led_pkg;

  localparam int unsigned LED_PERIOD_W = 16;
  localparam int unsigned LED_PWM_W    = 8;

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    ON    = 2'd1,
    BLINK = 2'd2,
    PWM   = 2'd3
  } led_mode_t;

  // Default-width payload; modules with overridden widths declare their own twin.
  typedef struct packed {
    led_mode_t                 mode;
    logic [LED_PERIOD_W-1:0]   half_period;
    logic [LED_PWM_W-1:0]      duty;
  } led_cfg_t;

endpackage

// File: rtl/tick_gen.sv
// Timebase prescaler: emits a one-cycle tick every CLK_FREQ_HZ/TICK_HZ enabled cycles.
// Disabling clears the prescaler so the next tick is a full period away.
module tick_gen #(
  parameter int unsigned CLK_FREQ_HZ = 100_000_000,
  parameter int unsigned TICK_HZ     = 1000
) (
  input  logic sys_clk,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam int unsigned DIV   = CLK_FREQ_HZ / TICK_HZ;
  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] TERM = CNT_W'(DIV - 1);

  if (((CLK_FREQ_HZ % TICK_HZ) != 0) || (DIV < 2)) begin : g_bad_div
    $error("tick_gen: CLK_FREQ_HZ must be a multiple of TICK_HZ with quotient >= 2");
  end

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  // tick_q is registered so it is high exactly while cnt_q sits at TERM.
  always_comb begin
    cnt_d  = '0;
    tick_d = 1'b0;
    if (enable) begin
      cnt_d  = (cnt_q == TERM) ? '0 : cnt_q + CNT_W'(1);
      tick_d = (cnt_d == TERM);
    end
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/led_pattern_driver.sv
// Multi-channel status-LED driver: per-channel OFF/ON/BLINK/PWM with a valid/ready
// configuration port; all LED activity is gated by the PLL lock flag.
module led_pattern_driver
  import led_pkg::*;
#(
  parameter int unsigned NUM_LEDS            = 2,
  parameter int unsigned CLK_FREQ_HZ         = 100_000_000,
  parameter int unsigned TICK_HZ             = 1000,
  parameter int unsigned PERIOD_W            = 16,
  parameter int unsigned PWM_W               = 8,
  parameter int unsigned DEFAULT_HALF_PERIOD = 1000
) (
  input  logic                sys_clk,
  input  logic                reset,
  input  logic                locked,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [3:0]          cfg_channel,
  input  led_mode_t           cfg_mode,
  input  logic [PERIOD_W-1:0] cfg_half_period,
  input  logic [PWM_W-1:0]    cfg_duty,
  output logic                cfg_error,
  output logic [NUM_LEDS-1:0] leds
);

  localparam int unsigned CH_W = 4;

  if ((NUM_LEDS < 1) || (NUM_LEDS > 16)) begin : g_bad_num_leds
    $error("led_pattern_driver: NUM_LEDS must be in 1..16");
  end

  typedef struct packed {
    led_mode_t           mode;
    logic [PERIOD_W-1:0] half_period;
    logic [PWM_W-1:0]    duty;
  } ch_cfg_t;

  logic                tick;
  logic                cfg_ready_q;
  logic                cfg_error_q, cfg_error_d;
  logic [PWM_W-1:0]    pwm_cnt_q, pwm_cnt_d;
  logic [NUM_LEDS-1:0] leds_q, leds_d;
  logic                cfg_fire_c;
  logic                cfg_in_range_c;

  tick_gen #(
    .CLK_FREQ_HZ (CLK_FREQ_HZ),
    .TICK_HZ     (TICK_HZ)
  ) u_tick_gen (
    .sys_clk (sys_clk),
    .reset   (reset),
    .enable  (locked),
    .tick    (tick)
  );

  // One extra bit so NUM_LEDS=16 still compares correctly.
  assign cfg_fire_c     = cfg_valid & cfg_ready_q;
  assign cfg_in_range_c = (5'(cfg_channel) < 5'(NUM_LEDS));

  always_comb begin
    cfg_error_d = cfg_error_q | (cfg_fire_c & ~cfg_in_range_c);
    pwm_cnt_d   = locked ? pwm_cnt_q + PWM_W'(1) : '0;
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      cfg_ready_q <= 1'b0;
      cfg_error_q <= 1'b0;
      pwm_cnt_q   <= '0;
      leds_q      <= '0;
    end else begin
      cfg_ready_q <= 1'b1;
      cfg_error_q <= cfg_error_d;
      pwm_cnt_q   <= pwm_cnt_d;
      leds_q      <= leds_d;
    end
  end

  for (genvar i = 0; i < NUM_LEDS; i++) begin : g_ch
    ch_cfg_t             cfg_q, cfg_d;
    logic [PERIOD_W-1:0] count_q, count_d;
    logic [PERIOD_W-1:0] last_c;
    logic                phase_q, phase_d;
    logic                wr_c;
    logic                led_c;

    assign wr_c   = cfg_fire_c && (cfg_channel == CH_W'(i));
    // A zero half-period behaves as one tick.
    assign last_c = (cfg_q.half_period == '0) ? '0 : cfg_q.half_period - PERIOD_W'(1);

    // Write beats lock loss, which beats the blink tick.
    always_comb begin
      cfg_d   = cfg_q;
      count_d = count_q;
      phase_d = phase_q;
      if (wr_c) begin
        cfg_d.mode        = cfg_mode;
        cfg_d.half_period = cfg_half_period;
        cfg_d.duty        = cfg_duty;
        count_d           = '0;
        phase_d           = 1'b0;
      end else if (!locked) begin
        count_d = '0;
        phase_d = 1'b0;
      end else if (tick && (cfg_q.mode == BLINK)) begin
        if (count_q == last_c) begin
          count_d = '0;
          phase_d = ~phase_q;
        end else begin
          count_d = count_q + PERIOD_W'(1);
        end
      end
    end

    always_comb begin
      led_c = 1'b0;
      case (cfg_q.mode)
        OFF:     led_c = 1'b0;
        ON:      led_c = 1'b1;
        BLINK:   led_c = phase_q;
        PWM:     led_c = (pwm_cnt_q < cfg_q.duty);
        default: led_c = 1'b0;
      endcase
    end

    assign leds_d[i] = locked & led_c;

    always_ff @(posedge sys_clk) begin
      if (reset) begin
        cfg_q.mode        <= BLINK;
        cfg_q.half_period <= PERIOD_W'(DEFAULT_HALF_PERIOD);
        cfg_q.duty        <= '0;
        count_q           <= '0;
        phase_q           <= 1'b0;
      end else begin
        cfg_q   <= cfg_d;
        count_q <= count_d;
        phase_q <= phase_d;
      end
    end
  end

  assign cfg_ready = cfg_ready_q;
  assign cfg_error = cfg_error_q;
  assign leds      = leds_q;

endmodule
